// File: rtl/alpaca_ospfb_utils_pkg.sv
// Shared defaults, sample type and read-FSM state encoding for the OSPFB
// phase-rotation frame buffer.
package alpaca_ospfb_utils_pkg;

    localparam int FFT_LEN_DEF = 64;
    localparam int DEC_FAC_DEF = 48;
    localparam int WIDTH_DEF   = 16;

    typedef logic [WIDTH_DEF-1:0] sample_t;

    typedef enum logic {
        IDLE = 1'b0,
        READ = 1'b1
    } rd_state_e;

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port whose
// output register clears on reset and holds when no read is issued.
module sdp_ram #(
    parameter int DEPTH = 128,
    parameter int WIDTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             re_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i)  rdata_o <= '0;
        else if (re_i) rdata_o <= mem_q[raddr_i];
    end

endmodule

// File: rtl/ospfb_phase_rot_buf.sv
// Ping-pong frame buffer whose read-out start rotates by FFT_LEN-DEC_FAC per
// frame; define OSPFB_PHASE_ROT_EN to enable rotation, otherwise natural order.
module ospfb_phase_rot_buf
    import alpaca_ospfb_utils_pkg::*;
#(
    parameter int FFT_LEN = FFT_LEN_DEF,
    parameter int DEC_FAC = DEC_FAC_DEF,
    parameter int WIDTH   = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             valid,
    input  logic             ready,
    output logic             sop,
    output logic             overflow
);

    localparam int AW = $clog2(FFT_LEN);
    localparam logic [AW-1:0] LAST = AW'(FFT_LEN - 1);

    if ((FFT_LEN & (FFT_LEN - 1)) != 0 || FFT_LEN < 4 || DEC_FAC < 1 || DEC_FAC > FFT_LEN) begin : g_bad_cfg
        $error("ospfb_phase_rot_buf: invalid FFT_LEN/DEC_FAC");
    end

    logic            wr_bank_q, wr_bank_d;
    logic [AW-1:0]   wr_addr_q, wr_addr_d;
    logic [1:0]      full_q, full_d;
    logic            ovf_q, ovf_d;
    rd_state_e       state_q, state_d;
    logic            rd_bank_q, rd_bank_d;
    logic [AW-1:0]   rd_addr_q, rd_addr_d;
    logic [AW-1:0]   rd_cnt_q, rd_cnt_d;
    logic            valid_q, valid_d;
    logic            sop_q, sop_d;
    logic [AW-1:0]   shift_cur, shift_nx;
    logic            issue, rel, blocked, we;

`ifdef OSPFB_PHASE_ROT_EN
    localparam logic [AW-1:0] STEP = AW'(FFT_LEN - DEC_FAC);
    logic [AW-1:0] shift_q;

    // AW-bit wrap gives the mod-M advance for free.
    assign shift_cur = shift_q;
    assign shift_nx  = shift_q + STEP;

    always_ff @(posedge clk) begin
        if (!rst)     shift_q <= '0;
        else if (rel) shift_q <= shift_nx;
    end
`else
    assign shift_cur = '0;
    assign shift_nx  = '0;
`endif

    // Write side; a bank released this cycle is immediately writable again.
    always_comb begin
        issue = (state_q == READ) && (!valid_q || ready);
        rel   = issue && (rd_cnt_q == LAST);
        full_d = full_q;
        if (rel) full_d[rd_bank_q] = 1'b0;
        blocked   = full_d[wr_bank_q] && (wr_addr_q == '0);
        we        = en && !blocked;
        wr_bank_d = wr_bank_q;
        wr_addr_d = wr_addr_q;
        ovf_d     = ovf_q | (en && blocked);
        if (we) begin
            wr_addr_d = wr_addr_q + 1'b1;
            if (wr_addr_q == LAST) begin
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = ~wr_bank_q;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        rd_bank_d = rd_bank_q;
        rd_addr_d = rd_addr_q;
        rd_cnt_d  = rd_cnt_q;
        valid_d   = valid_q;
        sop_d     = sop_q;
        case (state_q)
            IDLE: begin
                if (full_q[rd_bank_q]) begin
                    state_d   = READ;
                    rd_cnt_d  = '0;
                    rd_addr_d = shift_cur;
                end
            end
            READ: begin
                if (issue) begin
                    rd_addr_d = rd_addr_q + 1'b1;
                    rd_cnt_d  = rd_cnt_q + 1'b1;
                end
                // Chain straight into the other bank to avoid a bubble.
                if (rel) begin
                    rd_bank_d = ~rd_bank_q;
                    rd_cnt_d  = '0;
                    rd_addr_d = shift_nx;
                    state_d   = full_q[~rd_bank_q] ? READ : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (issue) begin
            valid_d = 1'b1;
            sop_d   = (rd_cnt_q == '0);
        end else if (ready) begin
            valid_d = 1'b0;
            sop_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_bank_q <= 1'b0;
            wr_addr_q <= '0;
            full_q    <= 2'b00;
            ovf_q     <= 1'b0;
            state_q   <= IDLE;
            rd_bank_q <= 1'b0;
            rd_addr_q <= '0;
            rd_cnt_q  <= '0;
            valid_q   <= 1'b0;
            sop_q     <= 1'b0;
        end else begin
            wr_bank_q <= wr_bank_d;
            wr_addr_q <= wr_addr_d;
            full_q    <= full_d;
            ovf_q     <= ovf_d;
            state_q   <= state_d;
            rd_bank_q <= rd_bank_d;
            rd_addr_q <= rd_addr_d;
            rd_cnt_q  <= rd_cnt_d;
            valid_q   <= valid_d;
            sop_q     <= sop_d;
        end
    end

    sdp_ram #(
        .DEPTH (2 * FFT_LEN),
        .WIDTH (WIDTH)
    ) u_ram (
        .clk_i   (clk),
        .rst_n_i (rst),
        .we_i    (we),
        .waddr_i ({wr_bank_q, wr_addr_q}),
        .wdata_i (din),
        .re_i    (issue),
        .raddr_i ({rd_bank_q, rd_addr_q}),
        .rdata_o (dout)
    );

    assign valid    = valid_q;
    assign sop      = sop_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_ospfb_phase_rot_buf.sv
// Scoreboard bench for ospfb_phase_rot_buf at M=8, D=6; expected frame order
// follows OSPFB_PHASE_ROT_EN (rotated) or natural order when it is undefined.
module tb_ospfb_phase_rot_buf;
    import alpaca_ospfb_utils_pkg::*;

    localparam int M = 8;
    localparam int D = 6;

    typedef struct packed {
        sample_t d;
        logic    s;
    } exp_t;

    logic    clk = 1'b0;
    logic    rst;
    logic    en;
    sample_t din;
    sample_t dout;
    logic    valid;
    logic    ready;
    logic    sop;
    logic    overflow;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ospfb_phase_rot_buf #(
        .FFT_LEN (M),
        .DEC_FAC (D),
        .WIDTH   (16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .din      (din),
        .dout     (dout),
        .valid    (valid),
        .ready    (ready),
        .sop      (sop),
        .overflow (overflow)
    );

    function automatic int exp_shift(int k);
`ifdef OSPFB_PHASE_ROT_EN
        return (k * (M - D)) % M;
`else
        return 0;
`endif
    endfunction

    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_frame(int base, int k);
        exp_t e;
        for (int i = 0; i < M; i++) begin
            e.d = sample_t'(base + ((exp_shift(k) + i) % M));
            e.s = (i == 0);
            q.push_back(e);
        end
    endtask

    task automatic do_reset();
        rst   = 1'b0;
        en    = 1'b0;
        din   = '0;
        ready = 1'b1;
        q.delete();
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_valid", int'(valid), 0);
            check("rst_sop", int'(sop), 0);
            check("rst_overflow", int'(overflow), 0);
            check("rst_dout", int'(dout), 0);
        end
        rst = 1'b1;
    endtask

    task automatic drain(int budget);
        int n;
        n = 0;
        while (q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        check("drain_left", q.size(), 0);
        repeat (4) tick();
    endtask

    // Monitor: pops on every transfer and checks stall stability.
    initial begin
        exp_t    e;
        logic    stall_prev;
        sample_t held_d;
        logic    held_s;
        stall_prev = 1'b0;
        held_d     = '0;
        held_s     = 1'b0;
        forever begin
            @(negedge clk);
            if (rst === 1'b1) begin
                if (stall_prev) begin
                    check("hold_valid", int'(valid), 1);
                    check("hold_dout", int'(dout), int'(held_d));
                    check("hold_sop", int'(sop), int'(held_s));
                end
                if (valid && ready) begin
                    checks++;
                    if (q.size() == 0) begin
                        errors++;
                        $display("FAIL spurious_output actual=%0d expected=none", dout);
                    end else begin
                        e = q.pop_front();
                        check("dout", int'(dout), int'(e.d));
                        check("sop", int'(sop), int'(e.s));
                    end
                end
                stall_prev = valid && !ready;
                held_d     = dout;
                held_s     = sop;
            end else begin
                stall_prev = 1'b0;
            end
        end
    end

    initial begin
        int cyc;
        int sent;

        // Reset and first frame with latency check
        do_reset();
        push_frame(0, 0);
        for (int i = 0; i < M; i++) begin
            en  = 1'b1;
            din = sample_t'(i);
            tick();
        end
        en = 1'b0;
        tick();
        check("lat_valid_early", int'(valid), 0);
        tick();
        check("lat_valid", int'(valid), 1);
        check("lat_sop", int'(sop), 1);
        drain(50);

        // Continuous input: rotation (or natural order without the macro)
        do_reset();
        for (int k = 0; k < 5; k++) push_frame(k * M, k);
        for (int i = 0; i < 5 * M; i++) begin
            en  = 1'b1;
            din = sample_t'(i);
            tick();
        end
        en = 1'b0;
        drain(100);
        check("rot_overflow", int'(overflow), 0);

        // Backpressure: ready toggles, en every third cycle
        do_reset();
        push_frame(0, 0);
        push_frame(M, 1);
        cyc  = 0;
        sent = 0;
        while ((sent < 2 * M || q.size() != 0) && cyc < 400) begin
            ready = cyc[0];
            if (sent < 2 * M && (cyc % 3) == 0) begin
                en  = 1'b1;
                din = sample_t'(sent);
                sent++;
            end else begin
                en = 1'b0;
            end
            tick();
            cyc++;
        end
        en    = 1'b0;
        ready = 1'b1;
        check("bp_left", q.size(), 0);
        check("bp_overflow", int'(overflow), 0);
        repeat (4) tick();

        // Overflow: both banks fill under ready=0, third frame dropped
        do_reset();
        ready = 1'b0;
        push_frame(0, 0);
        push_frame(M, 1);
        for (int i = 0; i < 3 * M; i++) begin
            en  = 1'b1;
            din = sample_t'(i);
            tick();
            if (i == 2 * M - 1) check("ovf_before_drop", int'(overflow), 0);
        end
        en = 1'b0;
        check("ovf_set", int'(overflow), 1);
        check("ovf_valid_stalled", int'(valid), 1);
        ready = 1'b1;
        drain(100);
        check("ovf_sticky", int'(overflow), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
